pipelined_alu_muldiv: RTL and testbench
=======================================

Name: pipelined_alu_muldiv

Overview:
Parametrised successor to the 2-stage BPF ALU, generalised to DATA_WIDTH-bit operands. Adds real multiply, divide and modulus: multiply is fully pipelined, divide/mod use an iterative radix-2 unit with stall handshake. Opcode is sampled in the same cycle as operands. Results and predicate flags leave through a single in-order valid output. Sits in the packet-filter datapath between the register file/operand muxes and the accumulator writeback.

Parameters:
DATA_WIDTH, 32, operand/result width (≥8).
ENABLE_MULDIV, 1, 0 = opcodes 2/3/9 return error codes (CAFEDEAD/DEADBEEF/BEEFCAFE truncated to DATA_WIDTH) with fast latency.
CNT_W, $clog2(DATA_WIDTH)+1, divider iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  operands/opcode presented.
in_ready  out  1  ALU can accept this cycle.
A  in  DATA_WIDTH  operand A (accumulator).
B  in  DATA_WIDTH  operand B (X or immediate).
ALU_sel  in  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 or, 5 and, 6 lsh, 7 rsh, 8 not, 9 mod, A xor, others → 0.
out_valid  out  1  result/flags valid, one-cycle pulse per accepted op.
ALU_out  out  DATA_WIDTH  result.
eq, gt, ge, set  out  1 each  unsigned predicates of the accepted A,B (A==B, A>B, A>=B, (A&B)!=0).
div_by_zero  out  1  qualified by out_valid; op was 3 or 9 with B==0.

Behaviour:
- Accept = in_valid & in_ready at a rising edge. No downstream backpressure; consumer must take every out_valid pulse.
- Fast ops (all except 3/9, and mul): accepted at edge t → out_valid high in cycle after edge t+1 (latency 2), II=1. Stage 1 registers op results, flags, opcode, valid; stage 2 muxes into ALU_out.
- Mul: low DATA_WIDTH bits of A*B, same latency 2, II=1 (pipelined per stage boundary).
- Div/mod (ENABLE_MULDIV=1): restoring divider, one quotient bit per cycle, DATA_WIDTH iterations. Accepted at edge t → out_valid at edge t+DATA_WIDTH+2. in_ready low from cycle after acceptance until and including the cycle before out_valid; in_ready high in the out_valid cycle (back-to-back accept allowed).
- Fast ops already in flight when a div is accepted complete normally; ordering is preserved because div latency > 2.
- Div/mod by zero: no iteration, out_valid at t+2, ALU_out=0, div_by_zero=1 (BPF reject semantics). in_ready stays high.
- Shifts: shift amount = B unsigned; B ≥ DATA_WIDTH → ALU_out=0. rsh is logical.
- Add/sub wrap modulo 2^DATA_WIDTH. not ignores B.
- Flags: computed from accepted A,B regardless of opcode; presented with that op's out_valid; hold last value otherwise.
- ALU_out, flags, div_by_zero hold between pulses.
- Reset: out_valid=0, ALU_out=0, flags=0, div_by_zero=0, divider idle, counter=0, pipeline valids cleared. in_ready=0 while rst high, 1 first cycle after rst deasserts. Reset mid-division aborts it; no result ever emitted for the aborted op.
- in_valid with in_ready low: inputs ignored; caller must hold.

Test Plan:
- W=32: add 0xFFFFFFFF+2, sub 3-5 back-to-back, II=1 → out_valid at t+2,t+3; results 0x1, 0xFFFFFFFE; flags for (3,5): eq=0 gt=0 ge=0 set=1.
- W=32: div 100/7 at t=10 → in_ready low t=11..43, out_valid at t=44 with ALU_out=14; then mod 100/7 → 2 at +34.
- Div 5/0 → out_valid at t+2, ALU_out=0, div_by_zero=1, in_ready never drops.
- Shifts: 1<<31 → 0x80000000; 1<<40 → 0; 0x80000000>>31 → 1; mul 0x10000*0x10000 → 0.
- Reset asserted 10 cycles into a div → no out_valid for it; in_ready=1 cycle after release; new add returns correctly.
- W=16, ENABLE_MULDIV=0: div op → 0xBEEF at latency 2, in_ready stays high; add 0xFFFF+1 → 0.

Source files
------------

// File: rtl/pipelined_alu_muldiv.sv
// rtl/pipelined_alu_muldiv.sv - two-stage ALU with pipelined multiply and iterative radix-2 divide/modulus
module pipelined_alu_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter bit ENABLE_MULDIV = 1'b1,
    parameter int CNT_W         = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALU_sel,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] ALU_out,
    output logic                  eq,
    output logic                  gt,
    output logic                  ge,
    output logic                  set,
    output logic                  div_by_zero
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LSH = 4'h6;
    localparam logic [3:0] OP_RSH = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_MOD = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;

    localparam logic [DATA_WIDTH-1:0] ERR_MUL = DATA_WIDTH'(32'hCAFE_DEAD);
    localparam logic [DATA_WIDTH-1:0] ERR_DIV = DATA_WIDTH'(32'hDEAD_BEEF);
    localparam logic [DATA_WIDTH-1:0] ERR_MOD = DATA_WIDTH'(32'hBEEF_CAFE);

    logic                  accept;
    logic                  is_divop;
    logic                  start_div;
    logic                  take_fast;
    logic [3:0]            in_flags;

    logic                  s1_valid;
    logic [3:0]            s1_op;
    logic [3:0]            s1_flags;
    logic                  s1_dbz;
    logic [DATA_WIDTH-1:0] s1_add;
    logic [DATA_WIDTH-1:0] s1_sub;
    logic [DATA_WIDTH-1:0] s1_mul;
    logic [DATA_WIDTH-1:0] s1_or;
    logic [DATA_WIDTH-1:0] s1_and;
    logic [DATA_WIDTH-1:0] s1_xor;
    logic [DATA_WIDTH-1:0] s1_not;
    logic [DATA_WIDTH-1:0] s1_shl;
    logic [DATA_WIDTH-1:0] s1_shr;
    logic [DATA_WIDTH-1:0] fast_result;

    logic                  busy;
    logic                  div_done;
    logic                  div_mod;
    logic [3:0]            div_flags;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dvs;
    logic [DATA_WIDTH:0]   rem_shift;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_next;

    // Ready drops for the whole division, including the cycle the final quotient bit settles.
    assign in_ready  = !rst && !busy && !div_done;
    assign accept    = in_valid && in_ready;
    assign is_divop  = ENABLE_MULDIV && (ALU_sel == OP_DIV || ALU_sel == OP_MOD);
    assign start_div = accept && is_divop && (B != '0);
    assign take_fast = accept && !start_div;

    always_comb begin
        in_flags = {A == B, A > B, A >= B, (A & B) != '0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_flags <= '0;
            s1_dbz   <= 1'b0;
            s1_add   <= '0;
            s1_sub   <= '0;
            s1_mul   <= '0;
            s1_or    <= '0;
            s1_and   <= '0;
            s1_xor   <= '0;
            s1_not   <= '0;
            s1_shl   <= '0;
            s1_shr   <= '0;
        end else begin
            s1_valid <= take_fast;
            if (take_fast) begin
                s1_op    <= ALU_sel;
                s1_flags <= in_flags;
                s1_dbz   <= is_divop && (B == '0);
                s1_add   <= A + B;
                s1_sub   <= A - B;
                s1_mul   <= ENABLE_MULDIV ? A * B : '0;
                s1_or    <= A | B;
                s1_and   <= A & B;
                s1_xor   <= A ^ B;
                s1_not   <= ~A;
                // Shift amount is the whole of B, so any amount >= DATA_WIDTH yields zero.
                s1_shl   <= A << B;
                s1_shr   <= A >> B;
            end
        end
    end

    // Restoring step: shift in the next dividend bit, subtract the divisor when it fits.
    always_comb begin
        rem_shift = {rem, quo[DATA_WIDTH-1]};
        q_bit     = rem_shift >= {1'b0, dvs};
        rem_next  = q_bit ? DATA_WIDTH'(rem_shift - {1'b0, dvs}) : rem_shift[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            div_done  <= 1'b0;
            div_mod   <= 1'b0;
            div_flags <= '0;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
        end else if (start_div) begin
            busy      <= 1'b1;
            cnt       <= CNT_W'(DATA_WIDTH);
            rem       <= '0;
            quo       <= A;
            dvs       <= B;
            div_mod   <= (ALU_sel == OP_MOD);
            div_flags <= in_flags;
        end else if (busy) begin
            rem <= rem_next;
            quo <= {quo[DATA_WIDTH-2:0], q_bit};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy     <= 1'b0;
                div_done <= 1'b1;
            end
        end else if (div_done) begin
            div_done <= 1'b0;
        end
    end

    always_comb begin
        fast_result = '0;
        case (s1_op)
            OP_ADD:  fast_result = s1_add;
            OP_SUB:  fast_result = s1_sub;
            OP_MUL:  fast_result = ENABLE_MULDIV ? s1_mul : ERR_MUL;
            // With muldiv enabled, div/mod only take the fast path on a zero divisor.
            OP_DIV:  fast_result = ENABLE_MULDIV ? '0 : ERR_DIV;
            OP_MOD:  fast_result = ENABLE_MULDIV ? '0 : ERR_MOD;
            OP_OR:   fast_result = s1_or;
            OP_AND:  fast_result = s1_and;
            OP_LSH:  fast_result = s1_shl;
            OP_RSH:  fast_result = s1_shr;
            OP_NOT:  fast_result = s1_not;
            OP_XOR:  fast_result = s1_xor;
            default: fast_result = '0;
        endcase
    end

    // Fast ops and a finished division can never collide: nothing is accepted while dividing.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            ALU_out     <= '0;
            eq          <= 1'b0;
            gt          <= 1'b0;
            ge          <= 1'b0;
            set         <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (s1_valid) begin
            out_valid         <= 1'b1;
            ALU_out           <= fast_result;
            {eq, gt, ge, set} <= s1_flags;
            div_by_zero       <= s1_dbz;
        end else if (div_done) begin
            out_valid         <= 1'b1;
            ALU_out           <= div_mod ? rem : quo;
            {eq, gt, ge, set} <= div_flags;
            div_by_zero       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_alu_muldiv.sv
// tb/tb_pipelined_alu_muldiv.sv - self-checking bench for pipelined_alu_muldiv (W=32 muldiv, W=16 no muldiv)
module tb_pipelined_alu_muldiv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv0 = 1'b0, iv1 = 1'b0;
    logic [3:0]  sel0 = '0, sel1 = '0;
    logic [31:0] a0 = '0, b0 = '0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        rdy0, rdy1, ov0, ov1, dz0, dz1;
    logic        eq0, gt0, ge0, set0, eq1, gt1, ge1, set1;
    logic [31:0] alu0;
    logic [15:0] alu1;

    pipelined_alu_muldiv #(.DATA_WIDTH(32), .ENABLE_MULDIV(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .A(a0), .B(b0), .ALU_sel(sel0),
        .out_valid(ov0), .ALU_out(alu0), .eq(eq0), .gt(gt0), .ge(ge0), .set(set0), .div_by_zero(dz0)
    );

    pipelined_alu_muldiv #(.DATA_WIDTH(16), .ENABLE_MULDIV(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .A(a1), .B(b1), .ALU_sel(sel1),
        .out_valid(ov1), .ALU_out(alu1), .eq(eq1), .gt(gt1), .ge(ge1), .set(set1), .div_by_zero(dz1)
    );

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        dz;
        bit          has_lr;
        logic [31:0] lr;
        bit          has_lf;
        logic [3:0]  lf;
    } exp_t;

    exp_t        q[2][$];
    int          cyc = 0;
    int          blocked[2] = '{-1, -1};
    int          total = 0;
    int          passed = 0;
    logic [31:0] last_res[2] = '{32'h0, 32'h0};
    logic [3:0]  last_fl[2] = '{4'h0, 4'h0};
    logic        last_dz[2] = '{1'b0, 1'b0};

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d cyc=%0d: got %0h, expected %0h", name, d, cyc, act, exp);
    endtask

    function automatic logic [32:0] model(input int w, input bit en, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m, r;
        logic        z;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        r = '0;
        z = 1'b0;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = en ? a * b : 32'hCAFE_DEAD;
            4'h3: if (!en) r = 32'hDEAD_BEEF; else if (b == 0) z = 1'b1; else r = a / b;
            4'h9: if (!en) r = 32'hBEEF_CAFE; else if (b == 0) z = 1'b1; else r = a % b;
            4'h4: r = a | b;
            4'h5: r = a & b;
            4'h6: r = (b >= 32'(w)) ? 32'h0 : a << b;
            4'h7: r = (b >= 32'(w)) ? 32'h0 : a >> b;
            4'h8: r = ~a;
            4'hA: r = a ^ b;
            default: r = '0;
        endcase
        return {z, r & m};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                blocked[d] = -1;
                last_res[d] = '0;
                last_fl[d] = '0;
                last_dz[d] = 1'b0;
            end
        end
    end

    task automatic send(input int d, input logic [3:0] op, input logic [31:0] a_raw, input logic [31:0] b_raw,
                        input bit hl, input logic [31:0] lr, input bit hf, input logic [3:0] lf);
        int          w;
        bit          en;
        bit          long_op;
        int          waited;
        logic [31:0] a, b, m;
        logic [32:0] r;
        exp_t        e;
        w = (d == 0) ? 32 : 16;
        en = (d == 0);
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a = a_raw & m;
        b = b_raw & m;
        waited = 0;
        @(negedge clk); #1;
        while (cyc <= blocked[d] && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        if (waited >= 100) begin
            total++;
            $display("FAIL send_ready_timeout dut%0d cyc=%0d: got not ready, expected ready", d, cyc);
        end
        if (d == 0) begin
            iv0 = 1'b1; sel0 = op; a0 = a; b0 = b;
        end else begin
            iv1 = 1'b1; sel1 = op; a1 = a[15:0]; b1 = b[15:0];
        end
        @(posedge clk); #1;
        long_op = en && (op == 4'h3 || op == 4'h9) && (b != 0);
        r = model(w, en, op, a, b);
        e.due = long_op ? cyc + w + 1 : cyc + 1;
        if (long_op) blocked[d] = cyc + w;
        e.res = r[31:0];
        e.dz = r[32];
        e.fl = {a == b, a > b, a >= b, (a & b) != 0};
        e.has_lr = hl;
        e.lr = lr;
        e.has_lf = hf;
        e.lf = lf;
        q[d].push_back(e);
    endtask

    task automatic op_lit(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lr);
        send(d, op, a, b, 1'b1, lr, 1'b0, 4'h0);
    endtask

    task automatic idle(input int d, input int n);
        @(negedge clk); #1;
        if (d == 0) iv0 = 1'b0; else iv1 = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        o, r, dz;
            logic [31:0] act;
            logic [3:0]  fl;
            bit          exp_o;
            exp_t        e;
            o   = (d == 0) ? ov0 : ov1;
            r   = (d == 0) ? rdy0 : rdy1;
            act = (d == 0) ? alu0 : {16'h0, alu1};
            fl  = (d == 0) ? {eq0, gt0, ge0, set0} : {eq1, gt1, ge1, set1};
            dz  = (d == 0) ? dz0 : dz1;
            check("in_ready", d, 32'(r), 32'(!rst && cyc > blocked[d]));
            exp_o = (q[d].size() > 0) && (q[d][0].due == cyc);
            check("out_valid", d, 32'(o), 32'(exp_o));
            if (!o) begin
                check("hold_alu_out", d, act, last_res[d]);
                check("hold_flags", d, 32'(fl), 32'(last_fl[d]));
                check("hold_div_by_zero", d, 32'(dz), 32'(last_dz[d]));
            end
            if (exp_o) begin
                e = q[d].pop_front();
                if (o) begin
                    check("alu_out", d, act, e.res);
                    check("flags", d, 32'(fl), 32'(e.fl));
                    check("div_by_zero", d, 32'(dz), 32'(e.dz));
                    if (e.has_lr) check("alu_out_literal", d, act, e.lr);
                    if (e.has_lf) check("flags_literal", d, 32'(fl), 32'(e.lf));
                end
                last_res[d] = e.res;
                last_fl[d] = e.fl;
                last_dz[d] = e.dz;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 0, 32'(ov0), 32'h0);
        check("reset_alu_out", 0, alu0, 32'h0);
        check("reset_flags", 0, 32'({eq0, gt0, ge0, set0, dz0}), 32'h0);
        check("reset_in_ready", 0, 32'(rdy0), 32'h0);
        check("reset_out_valid", 1, 32'(ov1), 32'h0);
        check("reset_alu_out", 1, 32'(alu1), 32'h0);
        check("reset_flags", 1, 32'({eq1, gt1, ge1, set1, dz1}), 32'h0);
        check("reset_in_ready", 1, 32'(rdy1), 32'h0);
        rst = 1'b0;

        // Wrap-around add and subtract, issued back to back.
        op_lit(0, 4'h0, 32'hFFFF_FFFF, 32'd2, 32'h1);
        send(0, 4'h1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b1, 4'b0001);
        idle(0, 3);

        // Division then modulus; the second op waits for ready to return.
        op_lit(0, 4'h3, 32'd100, 32'd7, 32'd14);
        op_lit(0, 4'h9, 32'd100, 32'd7, 32'd2);
        idle(0, 40);

        // Zero divisor takes the fast path and never drops ready.
        op_lit(0, 4'h3, 32'd5, 32'd0, 32'h0);
        op_lit(0, 4'h0, 32'd7, 32'd8, 32'd15);
        op_lit(0, 4'h9, 32'd9, 32'd0, 32'h0);

        // Shifts, multiply, logic and unused opcodes.
        op_lit(0, 4'h6, 32'd1, 32'd31, 32'h8000_0000);
        op_lit(0, 4'h6, 32'd1, 32'd40, 32'h0);
        op_lit(0, 4'h7, 32'h8000_0000, 32'd31, 32'h1);
        op_lit(0, 4'h7, 32'h8000_0000, 32'd32, 32'h0);
        op_lit(0, 4'h2, 32'h0001_0000, 32'h0001_0000, 32'h0);
        op_lit(0, 4'h2, 32'h1234, 32'h5678, 32'h0626_0060);
        op_lit(0, 4'h4, 32'h00F0_00F0, 32'h0F00_0F00, 32'h0FF0_0FF0);
        op_lit(0, 4'h5, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        op_lit(0, 4'h8, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987);
        op_lit(0, 4'hA, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        op_lit(0, 4'hF, 32'd5, 32'd6, 32'h0);
        op_lit(0, 4'hB, 32'd9, 32'd9, 32'h0);

        // Division corner cases.
        op_lit(0, 4'h3, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
        op_lit(0, 4'h9, 32'hFFFF_FFFF, 32'd10, 32'd5);
        op_lit(0, 4'h3, 32'd3, 32'd7, 32'd0);
        op_lit(0, 4'h9, 32'd3, 32'd7, 32'd3);
        send(0, 4'h3, 32'd7, 32'd7, 1'b1, 32'd1, 1'b1, 4'b1011);

        // Fast op in flight ahead of a division, then a fast op behind it.
        op_lit(0, 4'h0, 32'd1, 32'd1, 32'd2);
        op_lit(0, 4'h3, 32'd50, 32'd5, 32'd10);
        op_lit(0, 4'h1, 32'd10, 32'd4, 32'd6);
        idle(0, 40);

        // Reset ten cycles into a division: its result must never appear.
        op_lit(0, 4'h3, 32'd1000, 32'd3, 32'd333);
        idle(0, 10);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        op_lit(0, 4'h0, 32'd2, 32'd3, 32'd5);
        idle(0, 45);

        // 16-bit build without multiply/divide.
        op_lit(1, 4'h3, 32'h1234, 32'h0012, 32'hBEEF);
        op_lit(1, 4'h2, 32'd3, 32'd4, 32'hDEAD);
        op_lit(1, 4'h9, 32'd3, 32'd4, 32'hCAFE);
        op_lit(1, 4'h0, 32'hFFFF, 32'd1, 32'h0);
        op_lit(1, 4'h1, 32'd0, 32'd1, 32'hFFFF);
        op_lit(1, 4'h6, 32'd1, 32'd15, 32'h8000);
        op_lit(1, 4'h6, 32'd1, 32'd16, 32'h0);
        op_lit(1, 4'h7, 32'h8000, 32'd15, 32'h1);
        op_lit(1, 4'hA, 32'hA5A5, 32'h0FF0, 32'hAA55);
        idle(1, 6);

        @(negedge clk); #1;
        check("queue_drained", 0, 32'(q[0].size()), 32'h0);
        check("queue_drained", 1, 32'(q[1].size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
